// File: rtl/aes_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// aes_cmd_ctrl
//
// Command-side initiator for the AES core. Takes one command at a time from a
// valid/ready stream, launches key expansion, encryption or decryption on the
// core's one-shot enable inputs, holds the key/block/mode operands steady while
// the core works, and returns the result (or an error) on a valid/ready
// response channel. Also remembers whether a usable expanded key is present,
// rejects illegal requests without touching the core, counts completed blocks
// and abandons an operation the core never finishes.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 key expand, 01 encrypt, 10 decrypt, 11 illegal
//   cmd_mode256           1 = AES-256, 0 = AES-128
//   cmd_key, cmd_blk      command operands (AES-128 key lives in the top bits)
//   rsp_valid/rsp_ready   response handshake
//   rsp_blk, rsp_err      response payload
//   en_cipher/en_decipher/en_key   one-cycle start pulses to the core
//   aes128_mode/aes256_mode        core mode selects (always complementary)
//   aes_key, aes_in_blk            registered operands to the core
//   aes_out_blk, aes_op_in_progress, en_o   core result, busy and done pulse
//   key_loaded            a valid expanded key is present in the core
//   blk_count             completed encrypt/decrypt operations (wrapping)
// ---------------------------------------------------------------------------
module aes_cmd_ctrl #(
  parameter int KEY_W          = 256,
  parameter int BLK_W          = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_mode256,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [BLK_W-1:0] cmd_blk,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BLK_W-1:0] rsp_blk,
  output logic             rsp_err,
  // AES core interface
  output logic             en_cipher,
  output logic             en_decipher,
  output logic             en_key,
  output logic             aes128_mode,
  output logic             aes256_mode,
  output logic [KEY_W-1:0] aes_key,
  output logic [BLK_W-1:0] aes_in_blk,
  input  logic [BLK_W-1:0] aes_out_blk,
  input  logic             aes_op_in_progress,
  input  logic             en_o,
  // status
  output logic             key_loaded,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  // One spare bit so the counter can represent TIMEOUT_CYCLES - 1 for any size.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The watchdog register becomes TIMEOUT_CYCLES - 1 on the same edge that
  // moves the FSM to RESP, so the expiry test looks one count ahead.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      op_q;
  logic            mode_q;
  logic            loaded_mode;
  logic [WD_W-1:0] watchdog;
  logic            accept;
  logic            req_err;
  logic            wd_expire;
  logic            core_op;

  // A new command is only taken when the controller is idle and the core has
  // also gone quiet; after a watchdog abort the core may still be grinding on
  // the abandoned operation and must not receive an overlapping start.
  assign cmd_ready = (state == IDLE) && !aes_op_in_progress;
  assign accept    = cmd_valid && cmd_ready;

  // Cipher/decipher need an expanded key of the same width as the request;
  // the illegal opcode is always rejected. Rejected requests never reach the
  // core.
  assign core_op   = (cmd_op == OP_ENC) || (cmd_op == OP_DEC);
  assign req_err   = (cmd_op == OP_BAD) ||
                     (core_op && (!key_loaded || (cmd_mode256 != loaded_mode)));

  assign wd_expire = (watchdog == WD_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. ISSUE always lasts exactly one cycle; a done pulse that
  // coincides with watchdog expiry counts as a completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (en_o || wd_expire) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture. Key, block and mode are latched on every accepted
  // command (rejected ones included) and then left alone, so the core sees
  // stable operands from the start pulse until the next accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_KEY;
      mode_q      <= 1'b0;
      aes_key     <= '0;
      aes_in_blk  <= '0;
      aes128_mode <= 1'b1;
      aes256_mode <= 1'b0;
    end else if (accept) begin
      op_q        <= cmd_op;
      mode_q      <= cmd_mode256;
      aes_key     <= cmd_key;
      aes_in_blk  <= cmd_blk;
      aes128_mode <= !cmd_mode256;
      aes256_mode <= cmd_mode256;
    end
  end

  // Start pulses. They are registered at accept time so they are high for
  // exactly the ISSUE cycle and come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_key      <= 1'b0;
      en_cipher   <= 1'b0;
      en_decipher <= 1'b0;
    end else begin
      en_key      <= 1'b0;
      en_cipher   <= 1'b0;
      en_decipher <= 1'b0;
      if ((state == IDLE) && accept && !req_err) begin
        en_key      <= (cmd_op == OP_KEY);
        en_cipher   <= (cmd_op == OP_ENC);
        en_decipher <= (cmd_op == OP_DEC);
      end
    end
  end

  // Completion watchdog: cleared while the start pulse is out, counts every
  // WAIT cycle, and is otherwise left holding its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      watchdog <= '0;
    end else if (state == ISSUE) begin
      watchdog <= '0;
    end else if (state == WAIT) begin
      watchdog <= watchdog + 1'b1;
    end
  end

  // Response register. Payload is written once when entering RESP and is
  // held until the handshake; rsp_valid mirrors RESP occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_blk   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && req_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_blk   <= '0;
          end
        end
        WAIT: begin
          if (en_o) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_blk   <= (op_q == OP_KEY) ? '0 : aes_out_blk;
          end else if (wd_expire) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_blk   <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Key tracking. Starting a key expansion invalidates the old key because
  // the core overwrites its schedule; only a completed expansion makes a key
  // usable again. A timeout leaves the core in an unknown state, so the key
  // is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_loaded  <= 1'b0;
      loaded_mode <= 1'b0;
    end else begin
      if ((state == ISSUE) && (op_q == OP_KEY)) begin
        key_loaded <= 1'b0;
      end else if (state == WAIT) begin
        if (en_o) begin
          if (op_q == OP_KEY) begin
            key_loaded  <= 1'b1;
            loaded_mode <= mode_q;
          end
        end else if (wd_expire) begin
          key_loaded <= 1'b0;
        end
      end
    end
  end

  // Completed-block counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_count <= '0;
    end else if ((state == WAIT) && en_o && (op_q != OP_KEY)) begin
      blk_count <= blk_count + 1'b1;
    end
  end

  // Structural invariants of the core interface.
  a_en_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0({en_key, en_cipher, en_decipher}));
  a_mode_pair : assert property (@(posedge clk) disable iff (reset)
    aes256_mode != aes128_mode);
  a_rsp_state : assert property (@(posedge clk) disable iff (reset)
    rsp_valid == (state == RESP));

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_cmd_ctrl
//
// Self-checking bench for aes_cmd_ctrl. A behavioural stub of the AES core
// answers start pulses after a programmable latency (or hangs on request).
// A transaction-level model tracks key validity, key width and the block
// count, and predicts each response, its latency and the start pulses seen.
// ---------------------------------------------------------------------------
module tb_aes_cmd_ctrl;

  localparam int KEY_W = 256;
  localparam int BLK_W = 128;
  localparam int T     = 16;
  localparam int CNT_W = 32;

  localparam logic [127:0] KAT128_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KAT256_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT256_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_mode256;
  logic [KEY_W-1:0] cmd_key;
  logic [BLK_W-1:0] cmd_blk;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [BLK_W-1:0] rsp_blk;
  logic             rsp_err;
  logic             en_cipher;
  logic             en_decipher;
  logic             en_key;
  logic             aes128_mode;
  logic             aes256_mode;
  logic [KEY_W-1:0] aes_key;
  logic [BLK_W-1:0] aes_in_blk;
  logic [BLK_W-1:0] aes_out_blk;
  logic             aes_op_in_progress;
  logic             en_o;
  logic             key_loaded;
  logic [CNT_W-1:0] blk_count;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  logic         m_key_loaded  = 1'b0;
  logic         m_loaded_mode = 1'b0;
  logic [255:0] m_key         = '0;
  int           m_blk_count   = 0;

  // core stub controls and state
  int           core_lat  = 1;
  bit           core_hang = 1'b0;
  logic         core_busy;
  int           core_cnt;
  logic [255:0] core_key;
  logic         core_m256;
  logic [127:0] core_res;

  aes_cmd_ctrl #(
    .KEY_W(KEY_W), .BLK_W(BLK_W), .TIMEOUT_CYCLES(T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode256(cmd_mode256), .cmd_key(cmd_key), .cmd_blk(cmd_blk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_blk(rsp_blk),
    .rsp_err(rsp_err),
    .en_cipher(en_cipher), .en_decipher(en_decipher), .en_key(en_key),
    .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
    .aes_key(aes_key), .aes_in_blk(aes_in_blk), .aes_out_blk(aes_out_blk),
    .aes_op_in_progress(aes_op_in_progress), .en_o(en_o),
    .key_loaded(key_loaded), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Known-answer pairs for the published vectors, otherwise a cheap keyed
  // scramble; an AES-128 core ignores the low key half.
  function automatic logic [127:0] core_func(input logic [1:0] op, input logic [255:0] key,
                                             input logic m256, input logic [127:0] blk);
    logic [127:0] k;
    k = key[255:128] ^ (m256 ? key[127:0] : 128'h0);
    if (!m256 && key[255:128] == KAT128_KEY && op == 2'd1 && blk == KAT_PT) return KAT128_CT;
    if (m256 && key == KAT256_KEY && op == 2'd2 && blk == KAT256_CT) return KAT_PT;
    if (op == 2'd1) return {blk[63:0], blk[127:64]} ^ k;
    return ~blk ^ k;
  endfunction

  // Core stub: latches the key on en_key, computes on en_cipher/en_decipher,
  // pulses en_o core_lat cycles after it goes busy unless hung.
  assign aes_op_in_progress = core_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy   <= 1'b0;
      core_cnt    <= 0;
      core_key    <= '0;
      core_m256   <= 1'b0;
      core_res    <= '0;
      en_o        <= 1'b0;
      aes_out_blk <= '0;
    end else begin
      en_o <= 1'b0;
      if (en_key || en_cipher || en_decipher) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        if (en_key) begin
          core_key  <= aes_key;
          core_m256 <= aes256_mode;
          core_res  <= '0;
        end else begin
          core_res <= core_func(en_cipher ? 2'd1 : 2'd2, core_key, core_m256, aes_in_blk);
        end
      end else if (core_busy && !core_hang) begin
        if (core_cnt <= 1) begin
          en_o        <= 1'b1;
          core_busy   <= 1'b0;
          aes_out_blk <= core_res;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkOutput({tag, "_rsp_err"}, rsp_err, 1'b0);
    checkOutput({tag, "_rsp_blk"}, rsp_blk, '0);
    checkOutput({tag, "_en"}, {en_key, en_cipher, en_decipher}, 3'b000);
    checkOutput({tag, "_aes_key"}, aes_key, '0);
    checkOutput({tag, "_aes_in_blk"}, aes_in_blk, '0);
    checkOutput({tag, "_modes"}, {aes128_mode, aes256_mode}, 2'b10);
    checkOutput({tag, "_key_loaded"}, key_loaded, 1'b0);
    checkOutput({tag, "_blk_count"}, blk_count, '0);
  endtask

  // One complete command/response transaction, entered and left at #1 after
  // a rising edge. Expectations come from the transaction model.
  task automatic applyStimulus(input logic [1:0] op, input logic m256,
                               input logic [255:0] key, input logic [127:0] blk,
                               input int lat, input bit hang, input int hold,
                               input string tag);
    logic         issued, timeout, exp_err, ok_busy, ok_hold;
    logic [127:0] exp_blk;
    logic [2:0]   exp_en;
    int           exp_lat, k, waitn, nk, nc, nd;

    issued  = !(op == 2'd3 || (op != 2'd0 && (!m_key_loaded || m256 != m_loaded_mode)));
    timeout = issued && hang;
    exp_err = !issued || timeout;
    exp_lat = !issued ? 1 : (timeout ? T + 1 : lat + 3);
    exp_blk = (exp_err || op == 2'd0) ? 128'h0 : core_func(op, m_key, m_loaded_mode, blk);
    exp_en  = !issued ? 3'b000 : (op == 2'd0 ? 3'b100 : (op == 2'd1 ? 3'b010 : 3'b001));

    core_lat    = lat;
    core_hang   = hang;
    cmd_op      = op;
    cmd_mode256 = m256;
    cmd_key     = key;
    cmd_blk     = blk;
    cmd_valid   = 1'b1;
    waitn = 0;
    while (!cmd_ready && waitn < 64) begin
      @(posedge clk); #1;
      waitn++;
    end
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    checkOutput({tag, "_en_cycle1"}, {en_key, en_cipher, en_decipher}, exp_en);
    nk = 0; nc = 0; nd = 0; k = 1; ok_busy = 1'b1;
    while (!rsp_valid && k < 40) begin
      nk += int'(en_key);
      nc += int'(en_cipher);
      nd += int'(en_decipher);
      if (cmd_ready) ok_busy = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    checkOutput({tag, "_latency"}, k, exp_lat);
    checkOutput({tag, "_pulses"}, {8'(nk), 8'(nc), 8'(nd)},
                {8'(exp_en[2]), 8'(exp_en[1]), 8'(exp_en[0])});
    checkOutput({tag, "_busy_ready"}, ok_busy, 1'b1);

    if (issued && !timeout) begin
      if (op == 2'd0) begin
        m_key_loaded  = 1'b1;
        m_loaded_mode = m256;
        m_key         = key;
      end else begin
        m_blk_count++;
      end
    end
    if (timeout) m_key_loaded = 1'b0;

    checkOutput({tag, "_rsp_err"}, rsp_err, exp_err);
    checkOutput({tag, "_rsp_blk"}, rsp_blk, exp_blk);
    checkOutput({tag, "_key_loaded"}, key_loaded, m_key_loaded);
    checkOutput({tag, "_blk_count"}, blk_count, 32'(m_blk_count));
    checkOutput({tag, "_operands"}, {aes_key, aes_in_blk, aes256_mode, aes128_mode},
                {key, blk, m256, !m256});

    ok_hold = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_blk !== exp_blk || rsp_err !== exp_err ||
          cmd_ready !== 1'b0) ok_hold = 1'b0;
      @(posedge clk); #1;
    end
    if (hold > 0) checkOutput({tag, "_hold"}, ok_hold, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    checkOutput({tag, "_ready_after"}, cmd_ready, !timeout);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic ok;
    int   n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mode256 = 1'b0;
    cmd_key = '0; cmd_blk = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    checkOutput("reset_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] error requests");
    applyStimulus(2'd1, 1'b0, {KAT128_KEY, 128'h0}, KAT_PT, 3, 0, 0, "enc_nokey");
    applyStimulus(2'd3, 1'b0, rand256(), rand256()[127:0], 3, 0, 1, "illegal_op");

    $display("[TB] AES-128 known answer");
    applyStimulus(2'd0, 1'b0, {KAT128_KEY, 128'h0}, 128'h0, 4, 0, 0, "key128");
    applyStimulus(2'd1, 1'b0, {KAT128_KEY, 128'h0}, KAT_PT, 6, 0, 1, "enc128");
    applyStimulus(2'd1, 1'b1, {KAT128_KEY, 128'h0}, KAT_PT, 3, 0, 0, "enc_wrongmode");

    $display("[TB] AES-256 known answer with held response");
    applyStimulus(2'd0, 1'b1, KAT256_KEY, 128'h0, 2, 0, 0, "key256");
    applyStimulus(2'd2, 1'b1, KAT256_KEY, KAT256_CT, 5, 0, 20, "dec256");

    $display("[TB] watchdog");
    applyStimulus(2'd1, 1'b1, KAT256_KEY, KAT_PT, 2, 1, 2, "hang");
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("hang_ready_low", ok, 1'b1);
    core_hang = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("hang_release_ready", cmd_ready, 1'b1);
    checkOutput("late_done_ignored", {rsp_valid, key_loaded}, 2'b00);
    applyStimulus(2'd1, 1'b1, KAT256_KEY, KAT_PT, 2, 0, 0, "after_timeout");

    $display("[TB] randomized commands");
    for (int r = 0; r < 50; r++) begin
      logic [1:0] op;
      logic       m;
      int         p;
      p  = $urandom_range(0, 99);
      op = (p < 30) ? 2'd0 : (p < 60) ? 2'd1 : (p < 90) ? 2'd2 : 2'd3;
      m  = ($urandom_range(0, 99) < 80) ? m_loaded_mode : !m_loaded_mode;
      applyStimulus(op, m, rand256(), rand256()[127:0], $urandom_range(1, 10), 0,
                    $urandom_range(0, 3), "rnd");
    end

    $display("[TB] reset during WAIT");
    applyStimulus(2'd0, 1'b0, rand256(), 128'h0, 2, 0, 0, "rw_key");
    core_lat = 8; core_hang = 1'b0;
    cmd_op = 2'd1; cmd_mode256 = 1'b0; cmd_key = rand256(); cmd_blk = rand256()[127:0];
    cmd_valid = 1'b1;
    checkOutput("rw_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkResetValues("rst_wait");
    m_key_loaded = 1'b0; m_loaded_mode = 1'b0; m_blk_count = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'd1, 1'b0, rand256(), rand256()[127:0], 2, 0, 0, "post_rst_enc");

    $display("[TB] reset during ISSUE");
    core_lat = 4;
    cmd_op = 2'd0; cmd_mode256 = 1'b1; cmd_key = rand256(); cmd_valid = 1'b1;
    checkOutput("ri_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("ri_en_key_high", en_key, 1'b1);
    reset = 1'b1;
    #1;
    checkResetValues("rst_issue");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
